// File: rtl/ysyx_22041211_axi_rd_arbiter.sv
// Two-master AXI-lite read arbiter (m0 = IFU, m1 = LSU) in front of one slave.
// One complete AR+R transaction per grant; ties are resolved round-robin.
module ysyx_22041211_axi_rd_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  m0_ar_valid_i,
  input  logic [ADDR_WIDTH-1:0] m0_ar_addr_i,
  output logic                  m0_ar_ready_o,
  output logic [DATA_WIDTH-1:0] m0_r_data_o,
  output logic [1:0]            m0_r_resp_o,
  output logic                  m0_r_valid_o,
  input  logic                  m0_r_ready_i,

  input  logic                  m1_ar_valid_i,
  input  logic [ADDR_WIDTH-1:0] m1_ar_addr_i,
  output logic                  m1_ar_ready_o,
  output logic [DATA_WIDTH-1:0] m1_r_data_o,
  output logic [1:0]            m1_r_resp_o,
  output logic                  m1_r_valid_o,
  input  logic                  m1_r_ready_i,

  output logic                  s_ar_valid_o,
  output logic [ADDR_WIDTH-1:0] s_ar_addr_o,
  input  logic                  s_ar_ready_i,
  input  logic [DATA_WIDTH-1:0] s_r_data_i,
  input  logic [1:0]            s_r_resp_i,
  input  logic                  s_r_valid_i,
  output logic                  s_r_ready_o,

  output logic                  grant_o,
  output logic                  busy_o,
  output logic [1:0]            state_o
);

  // Handshakes: a transfer happens on a cycle where valid & ready are both 1;
  // valid never waits on ready, and this block only forwards each side's
  // valid/ready to the granted master, never to the other one.

  localparam logic [1:0] ARB_IDLE = 2'b00;
  localparam logic [1:0] ARB_ADDR = 2'b01;
  localparam logic [1:0] ARB_DATA = 2'b10;

  logic [1:0] state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_q,  last_d;

  logic                  own_ar_valid;
  logic [ADDR_WIDTH-1:0] own_ar_addr;
  logic                  own_r_ready;

  // Owner-side views of the master inputs; they only ever feed slave outputs.
  assign own_ar_valid = owner_q ? m1_ar_valid_i : m0_ar_valid_i;
  assign own_ar_addr  = owner_q ? m1_ar_addr_i  : m0_ar_addr_i;
  assign own_r_ready  = owner_q ? m1_r_ready_i  : m0_r_ready_i;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      ARB_IDLE: begin
        if (m0_ar_valid_i && m1_ar_valid_i) begin
          owner_d = ~last_q;
          state_d = ARB_ADDR;
        end else if (m0_ar_valid_i) begin
          owner_d = 1'b0;
          state_d = ARB_ADDR;
        end else if (m1_ar_valid_i) begin
          owner_d = 1'b1;
          state_d = ARB_ADDR;
        end
      end
      ARB_ADDR: begin
        if (own_ar_valid && s_ar_ready_i) begin
          state_d = ARB_DATA;
        end
      end
      ARB_DATA: begin
        if (s_r_valid_i && own_r_ready) begin
          last_d  = owner_q;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    m0_ar_ready_o = 1'b0;
    m0_r_data_o   = '0;
    m0_r_resp_o   = 2'b00;
    m0_r_valid_o  = 1'b0;
    m1_ar_ready_o = 1'b0;
    m1_r_data_o   = '0;
    m1_r_resp_o   = 2'b00;
    m1_r_valid_o  = 1'b0;
    s_ar_valid_o  = 1'b0;
    s_ar_addr_o   = '0;
    s_r_ready_o   = 1'b0;
    case (state_q)
      ARB_ADDR: begin
        s_ar_valid_o = own_ar_valid;
        s_ar_addr_o  = own_ar_valid ? own_ar_addr : '0;
        if (owner_q) m1_ar_ready_o = s_ar_ready_i;
        else         m0_ar_ready_o = s_ar_ready_i;
      end
      ARB_DATA: begin
        s_r_ready_o = own_r_ready;
        if (owner_q) begin
          m1_r_valid_o = s_r_valid_i;
          m1_r_data_o  = s_r_data_i;
          m1_r_resp_o  = s_r_resp_i;
        end else begin
          m0_r_valid_o = s_r_valid_i;
          m0_r_data_o  = s_r_data_i;
          m0_r_resp_o  = s_r_resp_i;
        end
      end
      default: ;
    endcase
  end

  assign busy_o  = (state_q == ARB_ADDR) || (state_q == ARB_DATA);
  assign grant_o = busy_o ? owner_q : 1'b0;
  assign state_o = state_q;

endmodule
